// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of a one-cycle-latency data memory: valid/ready request in,
// valid/ready response out, out-of-range addresses faulted. MEM_ACCESS_PERF_EN adds counters.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef ADDRESS_SPACE_W
`define ADDRESS_SPACE_W 1024
`endif

module mem_access_ctrl #(
  parameter int unsigned DATA_W = `REG_SIZE,
  parameter int unsigned DEPTH  = `ADDRESS_SPACE_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              mem_EN,
  output logic              mem_RW,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt,
  output logic [CNT_W-1:0]  fault_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  // One extra bit so DEPTH == 2**DATA_W still compares correctly.
  localparam logic [DATA_W:0] DepthExt = (DATA_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_fault_q, resp_fault_d;
  logic              addr_fault;
  logic              accept;

  assign addr_fault = {1'b0, req_addr} >= DepthExt;
  assign accept     = (state_q == StIdle) && req_valid && req_ready_q;

  always_comb begin
    state_d      = state_q;
    mem_en_d     = 1'b0;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (addr_fault) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_fault_d = 1'b1;
          end else begin
            // The mem_* registers double as the latched request.
            state_d     = StIssue;
            mem_en_d    = 1'b1;
            mem_rw_d    = req_we;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end
        end
      end
      StIssue: begin
        if (mem_rw_q) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_fault_d = 1'b0;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_rdata_d = mem_rdata;
        resp_fault_d = 1'b0;
      end
      StResp: begin
        if (resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign mem_EN     = mem_en_q;
  assign mem_RW     = mem_rw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

`ifdef MEM_ACCESS_PERF_EN
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    fault_cnt_d = fault_cnt_q;
    if (state_q == StIssue && !mem_rw_q) load_cnt_d  = load_cnt_q + CNT_W'(1);
    if (state_q == StIssue && mem_rw_q)  store_cnt_d = store_cnt_q + CNT_W'(1);
    if (accept && addr_fault)            fault_cnt_d = fault_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      fault_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
  assign fault_cnt = fault_cnt_q;
`else
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = CNT_W;
`endif

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store controller directly upstream of the data memory.
- Accepts one word-wide load or store request from the pipeline over a valid/ready handshake and drives the memory's enable, read/write, address and write-data inputs.
- Captures the memory's registered read data (one-cycle latency) and returns a response over a second valid/ready handshake.
- Blocks out-of-range addresses and reports them as faults without touching memory.

Parameters:
- DATA_W, default REG_SIZE: width of address, data and response words.
- DEPTH, default ADDRESS_SPACE_W: number of words in memory; legal addresses are 0..DEPTH-1.
- CNT_W, default 32: width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  DATA_W  word address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_W  load data; 0 for stores and faults.
- resp_fault  out  1  request address was >= DEPTH.
- mem_EN  out  1  memory enable.
- mem_RW  out  1  memory direction; 1 = write, 0 = read.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read enable.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE.
  - mem_EN=0, mem_RW=0, mem_addr=0, mem_wdata=0.
  - resp_valid=0, resp_rdata=0, resp_fault=0.
  - Internal request registers=0.
- Memory-side outputs come from registers and the state, never combinationally from req_*.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready=1; in every other state req_ready=0.
  - On req_valid&&req_ready, latch we/addr/wdata.
  - If addr >= DEPTH (full DATA_W unsigned compare), go to RESP with resp_fault=1 and resp_rdata=0. No memory access occurs.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_EN=1, mem_RW=latched we, mem_addr=latched addr, mem_wdata=latched wdata. The memory acts on the closing edge.
  - Store: go to RESP with resp_rdata=0, resp_fault=0.
  - Load: go to CAPTURE.
- CAPTURE (one cycle):
  - mem_EN=0.
  - resp_rdata <= mem_rdata, resp_fault <= 0; go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_fault are held stable until resp_valid&&resp_ready.
  - On that handshake go to IDLE and clear resp_valid. resp_rdata and resp_fault keep their values (don't care).
  - No new request is accepted in the same cycle as the response handshake.
- mem_EN=0 in every state except ISSUE. mem_addr, mem_wdata and mem_RW hold their last value when idle.
- Latency, counting the accept cycle as cycle 0:
  - load: ISSUE in cycle 1, CAPTURE in cycle 2, resp_valid in cycle 3.
  - store: resp_valid in cycle 2.
  - fault: resp_valid in cycle 1.
- Peak throughput:
  - one load per 4 cycles and one store per 3 cycles, with resp_ready held high.
- Backpressure: resp_ready low stalls indefinitely in RESP, with req_ready held 0.
- Reset mid-operation: the transaction is abandoned and mem_EN drops immediately.
  - A store is not performed unless its ISSUE edge occurred with rst_n=1.
  - No response is produced for an abandoned request.
- Boundaries:
  - addr=DEPTH-1 is legal; addr=DEPTH is a fault.
  - addr with upper bits set, e.g. all-ones, is a fault.
- req_* are ignored outside IDLE.

Optional Feature:
- Macro MEM_ACCESS_PERF_EN.
- When defined, add output ports load_cnt, store_cnt and fault_cnt, each CNT_W wide, reset to 0.
  - load_cnt increments on entry to CAPTURE.
  - store_cnt increments on a store's ISSUE cycle.
  - fault_cnt increments on accept of an out-of-range request.
  - All counters wrap modulo 2^CNT_W.
- When undefined, these ports and all counter logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset check: hold rst_n=0 and drive random req_* -> all outputs 0, req_ready=0 until release, then 1 in IDLE; mem_EN never 1.
- Store then load, each accepted in cycle 0:
  - Store addr=5, wdata=0xDEADBEEF -> mem_EN=1, mem_RW=1, mem_addr=5 in cycle 1; resp_valid in cycle 2 with resp_rdata=0, resp_fault=0.
  - Then load addr=5 -> mem_EN=1, mem_RW=0 in its cycle 1; resp_valid in its cycle 3 with resp_rdata=0xDEADBEEF.
- Fault: load addr=DEPTH, then store addr=all-ones -> resp_valid one cycle after each accept, resp_fault=1, resp_rdata=0, mem_EN stays 0 throughout; a following load of addr=5 still returns 0xDEADBEEF.
- Backpressure: load addr=DEPTH-1 (previously stored 0x12345678) with resp_ready=0 for 6 cycles:
  - resp_valid and resp_rdata=0x12345678 are held stable, and req_ready=0 while req_valid is held 1.
  - After resp_ready=1, one handshake occurs, then IDLE and req_ready=1.
- Reset mid-op: assert rst_n=0 during the ISSUE cycle of a store of 0xAAAA5555 to addr=7 (previously 0x1) -> no response; a subsequent load of addr=7 returns 0x1.
- With MEM_ACCESS_PERF_EN: 3 loads, 2 stores, 1 fault -> load_cnt=3, store_cnt=2, fault_cnt=1; preload the counters to all-ones and increment -> each wraps to 0.
